// File: rtl/mm_cache_ctrl_if.sv
// mm_cache_ctrl_if: CPU load/store port and main-memory bus of the cache controller
interface mm_cache_ctrl_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_ready;
  logic       cpu_busy;
  logic       MMRead;
  logic       MMWrite;
  logic [7:0] ABUS;
  logic [7:0] CachetoMem;
  logic [7:0] MemtoCache;
  logic [7:0] OldTag;
  logic       CacheSwap;
  logic [7:0] hit_cnt;
  logic [7:0] miss_cnt;
  modport master(
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, MemtoCache,
    output cpu_rdata, cpu_ready, cpu_busy, MMRead, MMWrite, ABUS, CachetoMem, OldTag, CacheSwap,
           hit_cnt, miss_cnt
  );
  modport slave(
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, MemtoCache,
    input  cpu_rdata, cpu_ready, cpu_busy, MMRead, MMWrite, ABUS, CachetoMem, OldTag, CacheSwap,
           hit_cnt, miss_cnt
  );
endinterface

// File: rtl/mm_cache_ctrl.sv
// mm_cache_ctrl: direct-mapped write-back write-allocate cache controller with one byte per line
module mm_cache_ctrl #(
  parameter int IDX_W    = 2,
  parameter int MEM_WAIT = 2
) (
  input logic            clk,
  input logic            reset,
  mm_cache_ctrl_if.master bus
);
  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 8 - IDX_W;
  localparam int CW    = $clog2(MEM_WAIT + 1);
  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;
  state_t           state;
  logic [7:0]       data [LINES];
  logic [TAG_W-1:0] tag  [LINES];
  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [7:0]       addr;
  logic [7:0]       wdata;
  logic             we;
  logic [CW-1:0]    cnt;
  logic [IDX_W-1:0] ridx;
  logic [IDX_W-1:0] lidx;
  logic             hit;
  logic             last;
  assign ridx = bus.cpu_addr[IDX_W-1:0];
  assign lidx = addr[IDX_W-1:0];
  // Lookup of the incoming request and end of the current memory window
  always_comb begin
    hit  = valid[ridx] && tag[ridx] == bus.cpu_addr[7:IDX_W];
    last = cnt == CW'(MEM_WAIT - 1);
  end
  // Controller FSM, line storage and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      valid          <= '0;
      dirty          <= '0;
      addr           <= '0;
      wdata          <= '0;
      we             <= 1'b0;
      cnt            <= '0;
      bus.cpu_rdata  <= '0;
      bus.cpu_ready  <= 1'b0;
      bus.cpu_busy   <= 1'b0;
      bus.MMRead     <= 1'b0;
      bus.MMWrite    <= 1'b0;
      bus.ABUS       <= '0;
      bus.CachetoMem <= '0;
      bus.OldTag     <= '0;
      bus.CacheSwap  <= 1'b0;
      bus.hit_cnt    <= '0;
      bus.miss_cnt   <= '0;
      for (int i = 0; i < LINES; i++) begin
        data[i] <= '0;
        tag[i]  <= '0;
      end
    end else begin
      bus.cpu_ready <= 1'b0;
      case (state)
        IDLE: if (bus.cpu_req) begin
          addr  <= bus.cpu_addr;
          we    <= bus.cpu_we;
          wdata <= bus.cpu_wdata;
          cnt   <= '0;
          if (hit) begin
            bus.cpu_ready <= 1'b1;
            bus.cpu_rdata <= bus.cpu_we ? bus.cpu_wdata : data[ridx];
            bus.hit_cnt   <= bus.hit_cnt + {7'd0, bus.hit_cnt != 8'hFF};
            if (bus.cpu_we) begin
              data[ridx]  <= bus.cpu_wdata;
              dirty[ridx] <= 1'b1;
            end
          end else begin
            bus.miss_cnt <= bus.miss_cnt + {7'd0, bus.miss_cnt != 8'hFF};
            bus.cpu_busy <= 1'b1;
            bus.ABUS     <= bus.cpu_addr;
            if (valid[ridx] && dirty[ridx]) begin
              state          <= WB;
              bus.MMWrite    <= 1'b1;
              bus.CacheSwap  <= 1'b1;
              bus.OldTag     <= {tag[ridx], ridx};
              bus.CachetoMem <= data[ridx];
            end else begin
              state      <= FILL;
              bus.MMRead <= 1'b1;
            end
          end
        end
        WB: begin
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) begin
            state         <= FILL;
            bus.MMWrite   <= 1'b0;
            bus.CacheSwap <= 1'b0;
            bus.MMRead    <= 1'b1;
          end
        end
        FILL: begin
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) begin
            state         <= RESP;
            bus.MMRead    <= 1'b0;
            data[lidx]    <= we ? wdata : bus.MemtoCache;
            tag[lidx]     <= addr[7:IDX_W];
            valid[lidx]   <= 1'b1;
            dirty[lidx]   <= we;
            bus.cpu_ready <= 1'b1;
            bus.cpu_rdata <= we ? wdata : bus.MemtoCache;
          end
        end
        default: begin
          state        <= IDLE;
          bus.cpu_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
